// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite pipeline: descriptor field layout,
// sprite geometry constants, selector FSM states and the per-line hit test.
package sprite_pkg;

  localparam int VIS_BIT = 31;
  localparam int X_MSB   = 28;
  localparam int X_LSB   = 19;
  localparam int Y_MSB   = 18;
  localparam int Y_LSB   = 9;
  localparam int OFF_MSB = 8;
  localparam int OFF_LSB = 0;

  localparam int          SPRITE_SIZE  = 20;
  localparam int          SPRITE_WORDS = 400;
  localparam logic [13:0] BG_ADDR      = 14'd16383;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_WAIT_X = 2'd2,
    ST_ACTIVE = 2'd3
  } sel_state_t;

  // Compared 11 bits wide so that y + SPRITE_SIZE never wraps.
  function automatic logic line_hit(input logic [31:0] d, input logic [9:0] ty);
    logic [10:0] y;
    logic [10:0] t;
    y = {1'b0, d[Y_MSB:Y_LSB]};
    t = {1'b0, ty};
    return d[VIS_BIT] && (t >= y) && (t < y + 11'(SPRITE_SIZE));
  endfunction

endpackage

// File: rtl/sprite_line_selector_if.sv
// Bundle of line timing, descriptor write port, downstream handshake and
// status outputs of the sprite line selector.
interface sprite_line_selector_if #(
  parameter int NUM_SPRITES = 32
);
  localparam int AW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic          new_line;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          counter_finished;
  logic [31:0]   sprite_datas;
  logic          sprite_on;
  logic          scan_busy;
  logic          overflow;
  logic          missed;

  modport master (
    output pixel_x, pixel_y, new_line, wr_en, wr_addr, wr_data, counter_finished,
    input  sprite_datas, sprite_on, scan_busy, overflow, missed
  );

  modport slave (
    input  pixel_x, pixel_y, new_line, wr_en, wr_addr, wr_data, counter_finished,
    output sprite_datas, sprite_on, scan_busy, overflow, missed
  );

endinterface

// File: rtl/sprite_slot_bank.sv
// Descriptor register file: synchronous write, combinational read so the
// scan sees the pre-write value of the slot it reads in the same cycle.
module sprite_slot_bank #(
  parameter int NUM_SPRITES = 32,
  parameter int AW          = 5
) (
  input  logic          clk_pixel,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] slot_reg [NUM_SPRITES];

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        slot_reg[i] <= '0;
      end
    end else if (wr_en) begin
      slot_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = slot_reg[rd_addr];

endmodule

// File: rtl/sprite_line_selector.sv
// Scans the descriptor bank for sprites on the next line, then hands hits to
// the downstream counter one at a time. Status flags built with SPRITE_SELECT_STATUS_EN.
module sprite_line_selector
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = 32,
  parameter int MAX_PER_LINE = 8,
  parameter int V_TOTAL      = 525
) (
  input logic                   clk_pixel,
  input logic                   reset_n,
  sprite_line_selector_if.slave bus
);

  localparam int AW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int LW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

  sel_state_t    state_reg, state_next;
  logic [AW-1:0] scan_idx_reg, scan_idx_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] rd_reg, rd_next;
  logic [9:0]    ty_reg, ty_next, target_y;
  logic          sprite_on_reg, sprite_on_next;
  logic [31:0]   sprite_datas_reg, sprite_datas_next;
  logic [31:0]   list_reg [MAX_PER_LINE];
  logic [31:0]   slot_data;
  logic [31:0]   cand;
  logic [9:0]    cand_x;
  logic          append, set_ovf, set_missed, clr_flags;

  sprite_slot_bank #(
    .NUM_SPRITES(NUM_SPRITES),
    .AW         (AW)
  ) u_bank (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_addr  (scan_idx_reg),
    .rd_data  (slot_data)
  );

  assign target_y = ({1'b0, bus.pixel_y} + 11'd1 == 11'(V_TOTAL)) ? 10'd0
                                                                  : bus.pixel_y + 10'd1;
  assign cand     = list_reg[rd_reg[LW-1:0]];
  assign cand_x   = cand[X_MSB:X_LSB];

  always_comb begin
    state_next        = state_reg;
    scan_idx_next     = scan_idx_reg;
    count_next        = count_reg;
    rd_next           = rd_reg;
    ty_next           = ty_reg;
    sprite_on_next    = sprite_on_reg;
    sprite_datas_next = sprite_datas_reg;
    append            = 1'b0;
    set_ovf           = 1'b0;
    set_missed        = 1'b0;
    clr_flags         = 1'b0;

    if (bus.new_line) begin
      // Start of blanking always wins, whatever was in progress.
      state_next     = ST_SCAN;
      scan_idx_next  = '0;
      count_next     = '0;
      rd_next        = '0;
      ty_next        = target_y;
      sprite_on_next = 1'b0;
      clr_flags      = 1'b1;
    end else begin
      case (state_reg)
        ST_SCAN: begin
          if (line_hit(slot_data, ty_reg)) begin
            if (count_reg < CW'(MAX_PER_LINE)) begin
              append     = 1'b1;
              count_next = count_reg + CW'(1);
            end else begin
              set_ovf = 1'b1;
            end
          end
          if (scan_idx_reg == AW'(NUM_SPRITES - 1)) begin
            state_next = (count_next != '0) ? ST_WAIT_X : ST_IDLE;
          end else begin
            scan_idx_next = scan_idx_reg + AW'(1);
          end
        end
        ST_WAIT_X: begin
          if (rd_reg == count_reg) begin
            state_next = ST_IDLE;
          end else if (bus.pixel_x == cand_x) begin
            sprite_on_next    = 1'b1;
            sprite_datas_next = cand;
            state_next        = ST_ACTIVE;
          end else if (bus.pixel_x > cand_x) begin
            set_missed = 1'b1;
            rd_next    = rd_reg + CW'(1);
          end
        end
        ST_ACTIVE: begin
          if (bus.counter_finished) begin
            sprite_on_next = 1'b0;
            rd_next        = rd_reg + CW'(1);
            state_next     = (rd_reg + CW'(1) < count_reg) ? ST_WAIT_X : ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      scan_idx_reg     <= '0;
      count_reg        <= '0;
      rd_reg           <= '0;
      ty_reg           <= '0;
      sprite_on_reg    <= 1'b0;
      sprite_datas_reg <= '0;
    end else begin
      state_reg        <= state_next;
      scan_idx_reg     <= scan_idx_next;
      count_reg        <= count_next;
      rd_reg           <= rd_next;
      ty_reg           <= ty_next;
      sprite_on_reg    <= sprite_on_next;
      sprite_datas_reg <= sprite_datas_next;
    end
  end

  // Hit list is pure data; count_reg qualifies which entries are live.
  always_ff @(posedge clk_pixel) begin
    if (append) begin
      list_reg[count_reg[LW-1:0]] <= slot_data;
    end
  end

  assign bus.sprite_on    = sprite_on_reg;
  assign bus.sprite_datas = sprite_datas_reg;
  assign bus.scan_busy    = (state_reg == ST_SCAN);

`ifdef SPRITE_SELECT_STATUS_EN
  logic overflow_reg;
  logic missed_reg;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg <= 1'b0;
      missed_reg   <= 1'b0;
    end else if (clr_flags) begin
      overflow_reg <= 1'b0;
      missed_reg   <= 1'b0;
    end else begin
      if (set_ovf)    overflow_reg <= 1'b1;
      if (set_missed) missed_reg   <= 1'b1;
    end
  end

  assign bus.overflow = overflow_reg;
  assign bus.missed   = missed_reg;
`else
  logic unused_flags;
  assign unused_flags = ^{set_ovf, set_missed, clr_flags};
  assign bus.overflow = 1'b0;
  assign bus.missed   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_selector.sv
// Self-checking bench for sprite_line_selector: queue-based line model,
// per-cycle output compare, directed scenarios and randomized lines.
module tb_sprite_line_selector;

  localparam int NS  = 32;
  localparam int MPL = 8;
  localparam int VT  = 525;
`ifdef SPRITE_SELECT_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  sprite_line_selector_if #(.NUM_SPRITES(NS)) bus ();

  sprite_line_selector #(
    .NUM_SPRITES (NS),
    .MAX_PER_LINE(MPL),
    .V_TOTAL     (VT)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: slot memory plus the ordered list of sprites still to show.
  logic [31:0] m_mem [NS];
  logic [31:0] m_q[$];
  int          m_scan_left;
  int          m_scan_slot;
  int          m_ty;
  logic        m_on, m_ovf, m_missed;
  logic [31:0] m_datas;
  int          m_on_len;
  bit          chk_en = 1'b0;

  // Stimulus controls and per-line observations.
  bit          pend_wr = 1'b0;
  logic [4:0]  pend_addr;
  logic [31:0] pend_data;
  bit          rand_wr = 1'b0;
  bit          spurious_cf = 1'b0;
  int          cf_len = 20;
  logic        prev_on = 1'b0;
  int          busy_cnt, on_cnt;
  logic [31:0] shown[$];
  int          rise_px[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_mem[i] = '0;
    m_q.delete();
    m_scan_left = 0;
    m_scan_slot = 0;
    m_ty        = 0;
    m_on        = 1'b0;
    m_ovf       = 1'b0;
    m_missed    = 1'b0;
    m_datas     = '0;
    m_on_len    = 0;
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    logic [31:0] d;
    int y, x;
    if (bus.new_line) begin
      m_ty = (int'(bus.pixel_y) + 1 == VT) ? 0 : int'(bus.pixel_y) + 1;
      m_scan_left = NS;
      m_scan_slot = 0;
      m_q.delete();
      m_on     = 1'b0;
      m_ovf    = 1'b0;
      m_missed = 1'b0;
    end else if (m_scan_left > 0) begin
      d = m_mem[m_scan_slot];
      y = int'(d[18:9]);
      if (d[31] && m_ty >= y && m_ty < y + 20) begin
        if (m_q.size() < MPL) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
      m_scan_slot++;
      m_scan_left--;
    end else if (m_on) begin
      if (bus.counter_finished) begin
        m_on = 1'b0;
        void'(m_q.pop_front());
      end else begin
        m_on_len++;
      end
    end else if (m_q.size() > 0) begin
      d = m_q[0];
      x = int'(d[28:19]);
      if (int'(bus.pixel_x) == x) begin
        m_on     = 1'b1;
        m_datas  = d;
        m_on_len = 1;
      end else if (int'(bus.pixel_x) > x) begin
        m_missed = 1'b1;
        void'(m_q.pop_front());
      end
    end
    if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
  endtask

  always @(negedge clk_pixel) begin
    if (chk_en && reset_n) begin
      check("sprite_on", {31'd0, bus.sprite_on}, {31'd0, m_on});
      check("sprite_datas", bus.sprite_datas, m_datas);
      check("scan_busy", {31'd0, bus.scan_busy}, {31'd0, m_scan_left > 0});
      check("overflow", {31'd0, bus.overflow}, {31'd0, STATUS_EN & m_ovf});
      check("missed", {31'd0, bus.missed}, {31'd0, STATUS_EN & m_missed});
    end
  end

  function automatic logic [31:0] rand_desc(input logic [9:0] py);
    int ty, y;
    ty = (int'(py) + 1 == VT) ? 0 : int'(py) + 1;
    y  = ty - int'($urandom_range(0, 24));
    if (y < 0) y = int'($urandom_range(0, 40));
    return {($urandom_range(0, 3) != 0), 2'($urandom), 10'($urandom_range(0, 639)),
            10'(y), 9'($urandom)};
  endfunction

  // One clock: drive inputs (we are at a negedge), step the model, observe.
  task automatic tick(input logic nl, input logic [9:0] px, input logic [9:0] py);
    bus.new_line = nl;
    bus.pixel_x  = px;
    bus.pixel_y  = py;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    if (pend_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = pend_addr;
      bus.wr_data = pend_data;
      pend_wr     = 1'b0;
    end else if (rand_wr && $urandom_range(0, 15) == 0) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'($urandom_range(0, NS - 1));
      bus.wr_data = rand_desc(py);
    end
    if (m_on) bus.counter_finished = (m_on_len >= cf_len);
    else      bus.counter_finished = spurious_cf && ($urandom_range(0, 7) == 0);
    @(posedge clk_pixel);
    model_step();
    @(negedge clk_pixel);
    if (bus.scan_busy) busy_cnt++;
    if (bus.sprite_on) on_cnt++;
    if (bus.sprite_on && !prev_on) begin
      shown.push_back(bus.sprite_datas);
      rise_px.push_back(int'(bus.pixel_x));
    end
    prev_on = bus.sprite_on;
  endtask

  task automatic write_slot(input int a, input logic [31:0] d);
    pend_wr   = 1'b1;
    pend_addr = 5'(a);
    pend_data = d;
    tick(1'b0, 10'd0, 10'd0);
  endtask

  task automatic run_line(input logic [9:0] py, input int abort_px);
    shown.delete();
    rise_px.delete();
    busy_cnt = 0;
    on_cnt   = 0;
    tick(1'b1, 10'd0, py);
    repeat (NS + 2) tick(1'b0, 10'd0, py);
    for (int px = 0; px < 640; px++) tick(px == abort_px, 10'(px), py);
  endtask

  initial begin
    logic [31:0] s;
    int          guard;
    logic [9:0]  py;

    bus.new_line = 1'b0; bus.pixel_x = '0; bus.pixel_y = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.counter_finished = 1'b0;
    model_reset();

    #12;
    check("rst_sprite_on", {31'd0, bus.sprite_on}, 32'd0);
    check("rst_sprite_datas", bus.sprite_datas, 32'd0);
    check("rst_scan_busy", {31'd0, bus.scan_busy}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_missed", {31'd0, bus.missed}, 32'd0);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Single sprite: vis, x=100, y=50, off=2.
    write_slot(3, 32'h8320_6402);
    run_line(10'd49, -1);
    check("s3_busy_len", busy_cnt, 32'd32);
    check("s3_shown_cnt", shown.size(), 32'd1);
    if (shown.size() > 0) check("s3_datas", shown[0], 32'h8320_6402);
    if (rise_px.size() > 0) check("s3_rise_px", rise_px[0], 32'd100);
    check("s3_on_len", on_cnt, 32'd20);

    run_line(10'd69, -1);
    check("noline_shown_cnt", shown.size(), 32'd0);
    check("noline_on_cycles", on_cnt, 32'd0);

    // Nine sprites on one line: only the first eight get shown.
    for (int i = 0; i < 9; i++)
      write_slot(i, {1'b1, 2'b00, 10'(40 * i), 10'd100, 9'd0});
    run_line(10'd100, -1);
    check("ovf_shown_cnt", shown.size(), 32'd8);
    for (int i = 0; i < 8 && i < shown.size(); i++) begin
      s = shown[i];
      check("ovf_order_x", {22'd0, s[28:19]}, 32'(40 * i));
    end
    check("ovf_flag", {31'd0, bus.overflow}, {31'd0, STATUS_EN});

    // Overlapping pair: the second is passed while the first is drawn.
    for (int i = 0; i < 9; i++) write_slot(i, 32'd0);
    write_slot(0, {1'b1, 2'b00, 10'd100, 10'd200, 9'd5});
    write_slot(1, {1'b1, 2'b00, 10'd110, 10'd200, 9'd6});
    run_line(10'd199, -1);
    check("miss_shown_cnt", shown.size(), 32'd1);
    if (rise_px.size() > 0) check("miss_rise_px", rise_px[0], 32'd100);
    check("miss_flag", {31'd0, bus.missed}, {31'd0, STATUS_EN});

    // Last line of the frame targets line 0.
    write_slot(1, 32'd0);
    write_slot(0, {1'b1, 2'b00, 10'd200, 10'd0, 9'd1});
    run_line(10'd524, -1);
    check("wrap_shown_cnt", shown.size(), 32'd1);
    if (rise_px.size() > 0) check("wrap_rise_px", rise_px[0], 32'd200);

    // Asynchronous reset while a sprite is being drawn.
    shown.delete(); rise_px.delete();
    tick(1'b1, 10'd0, 10'd524);
    guard = 0;
    for (int px = 0; px < 640 && !m_on; px++) begin
      tick(1'b0, (guard < NS + 2) ? 10'd0 : 10'(px), 10'd524);
      guard++;
    end
    check("reach_active", {31'd0, bus.sprite_on}, 32'd1);
    #2;
    reset_n = 1'b0;
    bus.counter_finished = 1'b0;
    bus.new_line = 1'b0;
    #1;
    check("arst_sprite_on", {31'd0, bus.sprite_on}, 32'd0);
    check("arst_sprite_datas", bus.sprite_datas, 32'd0);
    check("arst_scan_busy", {31'd0, bus.scan_busy}, 32'd0);
    check("arst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("arst_missed", {31'd0, bus.missed}, 32'd0);
    model_reset();
    prev_on = 1'b0;
    @(negedge clk_pixel);
    reset_n = 1'b1;
    run_line(10'd524, -1);
    check("post_rst_shown_cnt", shown.size(), 32'd0);

    // Randomized lines with writes during scan/display, aborts and stray finishes.
    rand_wr     = 1'b1;
    spurious_cf = 1'b1;
    for (int ln = 0; ln < 25; ln++) begin
      py     = 10'($urandom_range(0, VT - 1));
      cf_len = int'($urandom_range(1, 24));
      for (int k = 0; k < 8; k++) write_slot(int'($urandom_range(0, NS - 1)), rand_desc(py));
      run_line(py, ($urandom_range(0, 3) == 0) ? int'($urandom_range(50, 600)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
